mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter that shares the single-port byte memory (`memory_dut`) between `NUM_REQ` requesters. Each requester uses a valid/ready request channel and receives a one-cycle-later response carrying read data or a write acknowledge. The block sits between the requesting agents and the memory. It owns the memory's `wr_rd`/`addr`/`data_in` inputs and consumes its registered `data_out`.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2–8.
- `ADDR_W`, 32: address width; matches the memory address port.
- `DATA_W`, 8: data width; matches the memory data ports.
- `MEM_DEPTH`, 8: number of valid memory words; legal addresses are 0..MEM_DEPTH-1.
- Clock is `clock`. Reset is `reset`, asynchronous, active-low.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_wr`  in  NUM_REQ  1 = write, 0 = read, per requester.
- `req_addr`  in  NUM_REQ*ADDR_W  request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  one-hot response strobe.
- `rsp_wr`  out  1  response belongs to a write (acknowledge only).
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and for errors.
- `rsp_err`  out  1  address-range error on this response.
- `err_count`  out  16  saturating count of errored requests.
- `mem_wr_rd`  out  1  to memory `wr_rd`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_data_in`  out  DATA_W  to memory `data_in`.
- `mem_data_out`  in  DATA_W  from memory `data_out`; valid the cycle after a read is issued.

## Operation
- Arbitration:
  - Grant is combinational from `req_valid` and the registered priority pointer `rr_ptr`.
  - The first asserted requester at or after `rr_ptr`, searching with wrap-around, is granted.
  - At most one grant per cycle; `req_ready` is all-zero when no request is valid.
- Pointer update: on an accepted request from requester g, `rr_ptr <= (g+1) mod NUM_REQ`. With no acceptance, `rr_ptr` holds.
- Memory drive:
  - For a granted request, `mem_wr_rd`/`mem_addr`/`mem_data_in` combinationally equal the granted requester's `req_wr`/addr/wdata.
  - When idle, drive `mem_wr_rd=0`, `mem_addr=0`, `mem_data_in=0`. Idle reads are harmless, and `data_out` is not observed unless a response is pending.
- Response pipeline register holds `pend_valid`, `pend_id`, `pend_wr` and `pend_err`, loaded on each acceptance.
  - The cycle after acceptance, `rsp_valid[pend_id]=1` and `rsp_wr=pend_wr`.
  - `rsp_rdata = mem_data_out` for an error-free read; otherwise 0.
- Back-to-back: a new request is accepted every cycle. A response and a new grant coexist in the same cycle.
- No ordering hazard:
  - A read issued the cycle after a write to the same address returns the new data, because the memory write completes at the acceptance edge.
- Reset mid-operation:
  - Pending response is discarded (`rsp_valid` goes low immediately, asynchronously).
  - `rr_ptr` goes to 0. `err_count` clears.

## Timing
- Reset values: `req_ready`=0 (forced by reset), `rsp_valid`=0, `rsp_wr`=0, `rsp_rdata`=0, `rsp_err`=0, `err_count`=0, `mem_wr_rd`=0, `mem_addr`=0, `mem_data_in`=0, `rr_ptr`=0.
- Latency:
  - Acceptance at edge N. Memory performs the write, or captures read data, at edge N.
  - Response is visible in the cycle after edge N, cleared after edge N+1 unless another response is loaded.
- Throughput: 1 transaction per cycle aggregate. No requester waits more than NUM_REQ-1 grants while continuously valid.
- `req_valid` may drop without acceptance; the arbiter has no memory of withdrawn requests.

## Configuration
- Macro `MEM_PORT_ARBITER_ADDR_CHK_EN`.
- Defined:
  - A granted request with `req_addr >= MEM_DEPTH` is still accepted, but it is not forwarded: the memory sees the idle drive.
  - Its response carries `rsp_err=1` and `rsp_rdata=0`.
  - `err_count` increments, saturating at 16'hFFFF.
- Undefined:
  - Addresses pass through unchecked. `rsp_err` and `err_count` are tied 0.
  - Requesters must not issue out-of-range addresses.

## Test plan
- Single write then read:
  - Requester 0 writes addr 3 = 8'hA5, then reads addr 3 next cycle.
  - Expect `rsp_valid`=4'b0001 with `rsp_wr`=1, then `rsp_rdata`=8'hA5.
- All four requesters hold `req_valid` continuously for 8 cycles from reset.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect `rsp_valid` to follow the same order one cycle later.
- Fairness skip: requesters 1 and 3 valid, `rr_ptr`=2.
  - Expect grant 3, then 1, then 3.
- Reset mid-operation:
  - Assert `reset` low in the cycle after a read is accepted.
  - Expect `rsp_valid`=0 immediately and no response after release.
  - Next grant goes to requester 0.
- Range error (macro defined): requester 2 reads addr 32'd9.
  - Expect `rsp_valid[2]`=1, `rsp_err`=1, `rsp_rdata`=0, `err_count`=1, memory contents unchanged.
- Write/read same cycle pair:
  - Requester 1 writes addr 5 = 8'h3C while requester 2 reads addr 5 (granted next).
  - Expect requester 2's response `rsp_rdata`=8'h3C.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle for mem_port_arbiter: request channel
// (valid/ready with per-requester packed fields) and one-hot response strobe.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_wr;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    // Requesting agents drive the request fields and observe grant/response.
    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err
    );

    // The arbiter consumes requests and produces grant/response.
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port byte memory between NUM_REQ
// requesters. Grant and memory drive are combinational from req_valid and
// the registered priority pointer; responses appear one cycle after accept.
// Optional feature: define MEM_PORT_ARBITER_ADDR_CHK_EN to reject addresses
// >= MEM_DEPTH (accepted but not forwarded, flagged with rsp_err, counted).
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output logic [15:0]          err_count,
    output logic                 mem_wr_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data_in,
    input  logic [DATA_W-1:0]    mem_data_out
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    // Elaboration-time sanity check on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MEM_DEPTH < 1) begin : g_param_check
        $error("mem_port_arbiter: NUM_REQ must be 2..8 and MEM_DEPTH >= 1");
    end

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    logic              grant_any;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic              fwd;

    logic              pend_valid;
    logic [ID_W-1:0]   pend_id;
    logic              pend_wr;
    logic              pend_err;

    // Wrap-around search for the first valid requester at or after rr_ptr.
    // Reset gates the search so nothing is granted while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && bus.req_valid[idx] && reset) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Mux out the granted requester's fields.
    always_comb begin
        sel_wr    = bus.req_wr[grant_id];
        sel_addr  = bus.req_addr[32'(grant_id) * ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[32'(grant_id) * DATA_W +: DATA_W];
    end

`ifdef MEM_PORT_ARBITER_ADDR_CHK_EN
    assign sel_err = grant_any && !(sel_addr < ADDR_W'(MEM_DEPTH));
`else
    assign sel_err = 1'b0;
`endif

    assign fwd = grant_any && !sel_err;

    // Grant and memory drive; idle (or rejected) cycles drive an all-zero read.
    always_comb begin
        bus.req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
        mem_wr_rd     = fwd ? sel_wr    : 1'b0;
        mem_addr      = fwd ? sel_addr  : '0;
        mem_data_in   = fwd ? sel_wdata : '0;
    end

    // Priority pointer and response pipeline register, loaded on acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            pend_valid <= 1'b0;
            pend_id    <= '0;
            pend_wr    <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            pend_valid <= grant_any;
            if (grant_any) begin
                pend_id  <= grant_id;
                pend_wr  <= sel_wr;
                pend_err <= sel_err;
                rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                             : ID_W'(grant_id + ID_W'(1));
            end
        end
    end

`ifdef MEM_PORT_ARBITER_ADDR_CHK_EN
    // Saturating count of range-rejected requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (sel_err && err_count != {CNT_W{1'b1}}) begin
            err_count <= CNT_W'(err_count + CNT_W'(1));
        end
    end
`else
    assign err_count = '0;
`endif

    // Response outputs decoded from the pipeline register; data only for clean reads.
    always_comb begin
        bus.rsp_valid = pend_valid ? (NUM_REQ'(1) << pend_id) : '0;
        bus.rsp_wr    = pend_valid && pend_wr;
        bus.rsp_err   = pend_valid && pend_err;
        bus.rsp_rdata = (pend_valid && !pend_wr && !pend_err) ? mem_data_out : '0;
    end
endmodule
